// File: rtl/matsub_4x4_sched.sv
// matsub_4x4_sched: signed 4x4 matrix subtraction C = A - B, time-multiplexed over one 2x2 subtractor tile
//   clk, rst_n (async, active-low)
//   in_valid/in_ready   : operand handshake, A/B captured on accept (in_ready only in IDLE)
//   out_valid/out_ready : result handshake, C held in DONE until accepted
//   A, B, C             : 4x4 matrices of BIT_PREC-bit two's-complement elements, indexed [row][col]
//   busy                : not IDLE; tile_idx : tile being written during RUN, 0 otherwise
module matsub_4x4_sched #(
  parameter int BIT_PREC = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [3:0][3:0][BIT_PREC-1:0]      A,
  input  logic [3:0][3:0][BIT_PREC-1:0]      B,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [3:0][3:0][BIT_PREC-1:0]      C,
  output logic                               busy,
  output logic [1:0]                         tile_idx
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0][3:0][BIT_PREC-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [1:0][1:0][BIT_PREC-1:0] ta, tb, td;
  // counter bit 1 selects the row half, bit 0 the column half
  always_comb begin
    ta = '0;
    tb = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ta[i][j] = a_q[{cnt_q[1], 1'(i)}][{cnt_q[0], 1'(j)}];
        tb[i][j] = b_q[{cnt_q[1], 1'(i)}][{cnt_q[0], 1'(j)}];
      end
  end
  matsub_2x2 #(.W(BIT_PREC)) u_sub (.a_i(ta), .b_i(tb), .c_o(td));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        cnt_d   = 2'd0;
        a_d     = A;
        b_d     = B;
      end
      RUN: begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            c_d[{cnt_q[1], 1'(i)}][{cnt_q[0], 1'(j)}] = td[i][j];
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign tile_idx  = state_q == RUN ? cnt_q : 2'd0;
  assign C         = c_q;
endmodule

// matsub_2x2: combinational 2x2 element-wise wrap-around subtraction c_o = a_i - b_i
//   a_i, b_i, c_o : 2x2 matrices of W-bit elements, indexed [row][col]
module matsub_2x2 #(
  parameter int W = 8
) (
  input  logic [1:0][1:0][W-1:0] a_i,
  input  logic [1:0][1:0][W-1:0] b_i,
  output logic [1:0][1:0][W-1:0] c_o
);
  for (genvar i = 0; i < 2; i++) begin : g_r
    for (genvar j = 0; j < 2; j++) begin : g_c
      assign c_o[i][j] = a_i[i][j] - b_i[i][j];
    end
  end
endmodule
